// File: rtl/bird_hit_ctrl.sv
// rtl/bird_hit_ctrl.sv - per-bird hit, flash and life controller for the bird sprite
module bird_hit_ctrl #(
    parameter int HIT_POINTS       = 3,
    parameter int FLASH_FRAMES     = 8,
    parameter int WING_HALF_FRAMES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       birdDrawingRequest,
    input  logic       shotDrawingRequest,
    input  logic       respawn,
    output logic       flash,
    output logic       alive,
    output logic       duty50,
    output logic       birdHit,
    output logic       birdKilled,
    output logic [3:0] hitsLeft
);

    typedef enum logic [1:0] {
        ST_ALIVE    = 2'd0,
        ST_FLASHING = 2'd1,
        ST_DEAD     = 2'd2
    } state_t;

    localparam logic [3:0] HP_LOAD    = 4'(HIT_POINTS);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
    localparam logic [7:0] WING_LAST  = 8'(WING_HALF_FRAMES - 1);

    state_t     r_state;
    logic       r_col_flag;
    logic [7:0] r_flash_cnt;
    logic [7:0] r_wing_cnt;

    logic w_coinc;
    logic w_respawn_ok;

    assign w_coinc      = birdDrawingRequest && shotDrawingRequest;
    assign w_respawn_ok = respawn && (r_state == ST_DEAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ALIVE;
            r_col_flag  <= 1'b0;
            r_flash_cnt <= 8'd0;
            r_wing_cnt  <= 8'd0;
            hitsLeft    <= HP_LOAD;
            flash       <= 1'b0;
            alive       <= 1'b1;
            duty50      <= 1'b0;
            birdHit     <= 1'b0;
            birdKilled  <= 1'b0;
        end else begin
            birdHit    <= 1'b0;
            birdKilled <= 1'b0;
            if (w_respawn_ok) begin
                // Revival takes priority over a coincident frame evaluation.
                r_state     <= ST_ALIVE;
                r_col_flag  <= 1'b0;
                r_flash_cnt <= 8'd0;
                r_wing_cnt  <= 8'd0;
                hitsLeft    <= HP_LOAD;
                flash       <= 1'b0;
                alive       <= 1'b1;
                duty50      <= 1'b0;
            end else if (startOfFrame) begin
                // The flag restarts for the new frame; a coincidence right now belongs to it.
                r_col_flag <= w_coinc;
                if (r_state != ST_DEAD) begin
                    if (r_wing_cnt == WING_LAST) begin
                        r_wing_cnt <= 8'd0;
                        duty50     <= ~duty50;
                    end else begin
                        r_wing_cnt <= r_wing_cnt + 8'd1;
                    end
                end
                case (r_state)
                    ST_ALIVE: begin
                        if (r_col_flag) begin
                            birdHit <= 1'b1;
                            if (hitsLeft > 4'd1) begin
                                hitsLeft    <= hitsLeft - 4'd1;
                                r_flash_cnt <= FLASH_LOAD;
                                r_state     <= ST_FLASHING;
                                flash       <= 1'b1;
                            end else begin
                                hitsLeft   <= 4'd0;
                                birdKilled <= 1'b1;
                                r_state    <= ST_DEAD;
                                alive      <= 1'b0;
                            end
                        end
                    end
                    ST_FLASHING: begin
                        r_flash_cnt <= r_flash_cnt - 8'd1;
                        if (r_flash_cnt <= 8'd1) begin
                            r_state <= ST_ALIVE;
                            flash   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (w_coinc) begin
                r_col_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bird_hit_ctrl.md
# bird_hit_ctrl

Per-bird hit and life controller for the bird sprite in the Death Chase video path. It consumes the bird's drawing request and the player shot's drawing request at pixel rate, detects overlap once per frame, and tracks hit points. It drives the `flash`, `alive` and `duty50` controls that the bird draw stage consumes, and emits single-cycle hit and kill pulses for the score and shot logic.

## Interface
Parameters:
- `HIT_POINTS`, 3: hits needed to kill; legal range 1..15
- `FLASH_FRAMES`, 8: frames of red flash and invulnerability after a non-fatal hit; legal range 1..255
- `WING_HALF_FRAMES`, 6: frames per wing phase (duty50 toggle period); legal range 1..255

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `startOfFrame`  in  1  one-cycle pulse, once per video frame
- `birdDrawingRequest`  in  1  bird pixel is opaque and drawn (already gated by `alive`)
- `shotDrawingRequest`  in  1  player shot pixel is drawn
- `respawn`  in  1  one-cycle request to revive a dead bird
- `flash`  out  1  bird draws red
- `alive`  out  1  bird is alive and drawable
- `duty50`  out  1  wing phase (1 = wings up)
- `birdHit`  out  1  one-cycle pulse per accepted hit
- `birdKilled`  out  1  one-cycle pulse on the fatal hit
- `hitsLeft`  out  4  remaining hit points

## Operation
- States: ALIVE, FLASHING, DEAD. `alive` = (state != DEAD). `flash` = (state == FLASHING). All outputs are registered.
- Collision latch `colFlag`:
  - Set on any cycle where `birdDrawingRequest && shotDrawingRequest`.
  - Cleared on every `startOfFrame` cycle and on an accepted `respawn`.
  - A coincidence on the `startOfFrame` cycle itself sets the flag for the new frame.
- Frame evaluation happens on the `startOfFrame` cycle and uses the latched `colFlag` from the previous frame:
  - ALIVE, flag = 1, `hitsLeft` > 1: decrement `hitsLeft`, pulse `birdHit`, load `flashCnt` = FLASH_FRAMES, go to FLASHING.
  - ALIVE, flag = 1, `hitsLeft` = 1: set `hitsLeft` = 0, pulse `birdHit` and `birdKilled`, go to DEAD.
  - FLASHING: collisions are ignored (invulnerable). Decrement `flashCnt`; when it reaches 0, go to ALIVE.
  - DEAD: no change.
- At most one hit is accepted per frame, regardless of the number of overlapping pixels.
- Wing counter `wingCnt` (8-bit) runs in ALIVE and FLASHING only.
  - Increment on each `startOfFrame`.
  - When it reaches WING_HALF_FRAMES-1, wrap to 0 and toggle `duty50`.
  - Frozen in DEAD.
- `respawn`:
  - In DEAD: go to ALIVE, `hitsLeft` = HIT_POINTS, `wingCnt` = 0, `duty50` = 0, `flashCnt` = 0, clear `colFlag`.
  - In ALIVE or FLASHING: ignored.
  - If `respawn` and `startOfFrame` arrive in the same cycle in DEAD, `respawn` wins and the frame evaluation is skipped.

## Timing
- Reset values (asynchronous, take effect immediately on `reset` high):
  - state = ALIVE, `hitsLeft` = HIT_POINTS
  - `flash` = 0, `alive` = 1, `duty50` = 0
  - `birdHit` = 0, `birdKilled` = 0
  - `colFlag` = 0, `flashCnt` = 0, `wingCnt` = 0
- Reset asserted mid-FLASHING or in DEAD returns the block to the reset state. No pulse is emitted.
- Latency:
  - A `startOfFrame` sampled at edge N updates state, `hitsLeft`, `flash`, `alive` and `duty50` at edge N.
  - `birdHit` and `birdKilled` are high for exactly the cycle following edge N.
- Flash duration is exactly FLASH_FRAMES frame evaluations. `flash` falls at the FLASH_FRAMES-th `startOfFrame` after the hit.
- `alive` falls in the same cycle that `birdKilled` rises. Because the draw stage gates on `alive`, no further bird pixels are requested after the kill.
- `duty50` period is 2*WING_HALF_FRAMES frames while alive.
- A collision in the last cycle before `startOfFrame` counts toward the frame being evaluated.

## Test plan
- Reset, then a single coincident request cycle and a `startOfFrame` -> one-cycle `birdHit`, `hitsLeft` 3->2, `flash`=1. After 8 more `startOfFrame` pulses, `flash`=0 and state is ALIVE.
- 50 coincident cycles within one frame -> exactly one `birdHit`, `hitsLeft` decrements by 1 only.
- Collision during FLASHING -> no `birdHit`, `hitsLeft` unchanged, flash still ends on schedule.
- Three hits separated by full flash windows -> third evaluation gives `birdHit` and `birdKilled` in the same cycle, `hitsLeft`=0, `alive`=0, `duty50` frozen.
- `respawn` coincident with `startOfFrame` while DEAD -> `alive`=1, `hitsLeft`=3, `duty50`=0, no hit pulse. `respawn` while ALIVE -> no change.
- WING_HALF_FRAMES=6, no collisions -> `duty50` toggles every 6 `startOfFrame` pulses. `reset` asserted mid-FLASHING -> all outputs return to reset values immediately.
